conv2d_mc: RTL and testbench
============================

Name: conv2d_mc

Overview:
Multi-channel 2D convolution engine with a start/busy/done handshake. Computes one output feature map from IN_CHANNELS input planes. Adds zero padding, bias, and signed saturation to the single-channel conv2d. Uses one time-multiplexed MAC per cycle instead of a fully combinational kernel sum. Sits between the image/feature buffers and the next layer or activation stage of the accelerator datapath.

Parameters:
KERNEL_SIZE, 3, square kernel edge length (>=1)
WEIGHT_WIDTH, 8, signed weight width
DATA_WIDTH, 32, signed pixel, bias and output width
IN_CHANNELS, 2, number of input planes summed into one output plane
STRIDE, 1, step in x and y (>=1)
PADDING, 1, zero border in pixels on each side (>=0)
INPUT_WIDTH, 4, square input plane edge length
ACC_WIDTH, 64, accumulator width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(IN_CHANNELS*KERNEL_SIZE^2)
OUTPUT_WIDTH, derived localparam, (INPUT_WIDTH+2*PADDING-KERNEL_SIZE)/STRIDE+1

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a new frame; sampled only in IDLE
filter  in  IN_CHANNELS*KERNEL_SIZE^2*WEIGHT_WIDTH  signed weights; index ((c*K+ky)*K+kx)
bias  in  DATA_WIDTH  signed bias added once per output pixel
input_image  in  IN_CHANNELS*INPUT_WIDTH^2*DATA_WIDTH  signed pixels; index ((c*IW+y)*IW+x)
output_image  out  OUTPUT_WIDTH^2*DATA_WIDTH  signed results; index (oy*OW+ox)
busy  out  1  high in MAC and WRITE states
done  out  1  high from frame completion until the next accepted start or reset

Behaviour:
- Reset (sync, active-high): state=IDLE; busy=0; done=0; output_image=0; all counters and accumulator=0. Overrides any in-progress frame; a partial frame is discarded.
- States: IDLE, MAC, WRITE.
- IDLE:
  - start=1 -> MAC on the next edge; ox=oy=c=ky=kx=0; acc=sign-extended bias; done<=0.
  - start=0 -> remain in IDLE; done holds its value.
- MAC: one tap per cycle.
  - ix = ox*STRIDE+kx-PADDING, iy = oy*STRIDE+ky-PADDING.
  - acc += pixel*weight in full signed precision.
  - Out-of-range (ix,iy) contributes 0 (zero padding).
  - Tap order: kx fastest, then ky, then c.
  - After the tap c=IN_CHANNELS-1, ky=kx=K-1 -> WRITE.
- WRITE (1 cycle):
  - Saturate acc to DATA_WIDTH signed range: >2^(DW-1)-1 -> max; <-2^(DW-1) -> min.
  - Store the result at element (oy*OW+ox); reload acc=bias.
  - Advance ox, wrapping to 0 and incrementing oy.
  - If (ox,oy) was (OW-1,OW-1): done<=1 and go to IDLE; otherwise go to MAC.
- Per-pixel cost: IN_CHANNELS*K^2+1 cycles. done is registered high OW^2*(IN_CHANNELS*K^2+1) edges after the start-accept edge (304 with defaults).
- start while busy is ignored. start in IDLE with done=1 clears done and restarts.
- filter, bias and input_image must be held stable while busy. Changing them mid-frame gives undefined results but must not hang the FSM.
- output_image elements not yet written in the current frame keep their prior-frame values.

Optional Feature:
CONV2D_MC_RELU_EN:
- Defined: after saturation, negative results are written as 0 (fused ReLU). Latency is unchanged.
- Undefined: signed saturated values are written as-is.

Test Plan:
- Identity: C=2, ch0 centre weight 1, all other weights 0, bias 0, random pixels -> output_image equals ch0 plane; done after exactly 304 edges; busy=1 throughout.
- Padding: all pixels 1, all weights 1, bias 0 -> corners 8, edges 12, interior 18.
- Saturation: all pixels 0x7FFFFFFF, all weights 127 -> every output 0x7FFFFFFF. Pixels 0x80000000 with weights 127 -> 0x80000000.
- Bias/ReLU: all weights 0, bias -5 -> every output -5; 0 with CONV2D_MC_RELU_EN.
- Stride/no pad: STRIDE=2, PADDING=0, IW=5, K=3, pixel=x+y, ch0 weights 1, ch1 weights 0 -> OW=2; outputs 18,36,36,54.
- Control: start pulsed mid-frame -> ignored. reset asserted at cycle 100 -> next edge IDLE, busy=0, output_image=0. New start -> full correct frame.

Source files
------------

// File: rtl/conv2d_mc.sv
// Multi-channel 2D convolution engine: one MAC per cycle, zero padding, bias and signed saturation.
// Optional fused ReLU on the written results when CONV2D_MC_RELU_EN is defined.
module conv2d_mc #(
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IN_CHANNELS  = 2,
    parameter int unsigned STRIDE       = 1,
    parameter int unsigned PADDING      = 1,
    parameter int unsigned INPUT_WIDTH  = 4,
    parameter int unsigned ACC_WIDTH    = 64,
    localparam int unsigned OUTPUT_WIDTH = (INPUT_WIDTH + 2*PADDING - KERNEL_SIZE) / STRIDE + 1
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        start,
    input  logic [IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] filter,
    input  logic [DATA_WIDTH-1:0]                                       bias,
    input  logic [IN_CHANNELS*INPUT_WIDTH*INPUT_WIDTH*DATA_WIDTH-1:0]   input_image,
    output logic [OUTPUT_WIDTH*OUTPUT_WIDTH*DATA_WIDTH-1:0]             output_image,
    output logic                                                        busy,
    output logic                                                        done
);

    localparam int unsigned NUM_PIX = IN_CHANNELS * INPUT_WIDTH * INPUT_WIDTH;
    localparam int unsigned NUM_WT  = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned NUM_OUT = OUTPUT_WIDTH * OUTPUT_WIDTH;

    localparam int unsigned OW_W  = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
    localparam int unsigned K_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int unsigned C_W   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int unsigned PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int unsigned WT_W  = (NUM_WT > 1) ? $clog2(NUM_WT) : 1;
    localparam int unsigned OUT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam int S_I  = int'(STRIDE);
    localparam int P_I  = int'(PADDING);
    localparam int K_I  = int'(KERNEL_SIZE);
    localparam int IW_I = int'(INPUT_WIDTH);
    localparam int OW_I = int'(OUTPUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [OW_W-1:0] ox, oy;
    logic [C_W-1:0]  c;
    logic [K_W-1:0]  ky, kx;
    logic signed [ACC_WIDTH-1:0] acc;

    logic signed [DATA_WIDTH-1:0]   pixels  [NUM_PIX];
    logic signed [WEIGHT_WIDTH-1:0] weights [NUM_WT];
    logic        [DATA_WIDTH-1:0]   out_mem [NUM_OUT];

    logic last_tap, last_pix;
    int   ix, iy, pix_idx, wt_idx;
    logic in_range;
    logic signed [DATA_WIDTH-1:0]   pix_val;
    logic signed [WEIGHT_WIDTH-1:0] wt_val;
    logic signed [ACC_WIDTH-1:0]    pix_ext, wt_ext, prod, bias_ext;
    logic                           fits;
    logic [DATA_WIDTH-1:0]          sat_val, wr_val;
    logic [OUT_W-1:0]               out_idx;

    // Flat buses viewed as element arrays so all run-time indexing uses exact-width indices.
    for (genvar g = 0; g < int'(NUM_PIX); g++) begin : g_pix
        assign pixels[g] = input_image[g*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar g = 0; g < int'(NUM_WT); g++) begin : g_wt
        assign weights[g] = filter[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_out
        assign output_image[g*DATA_WIDTH +: DATA_WIDTH] = out_mem[g];
    end

    assign last_tap = (c == C_W'(IN_CHANNELS - 1)) && (ky == K_W'(KERNEL_SIZE - 1))
                   && (kx == K_W'(KERNEL_SIZE - 1));
    assign last_pix = (ox == OW_W'(OUTPUT_WIDTH - 1)) && (oy == OW_W'(OUTPUT_WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (last_tap) state_next = WRITE;
            WRITE:   state_next = last_pix ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
    end

    // Current tap: padded coordinates, operand fetch and full-precision product.
    always_comb begin
        ix       = int'(ox) * S_I + int'(kx) - P_I;
        iy       = int'(oy) * S_I + int'(ky) - P_I;
        in_range = (ix >= 0) && (ix < IW_I) && (iy >= 0) && (iy < IW_I);
        pix_idx  = (int'(c) * IW_I + iy) * IW_I + ix;
        wt_idx   = (int'(c) * K_I + int'(ky)) * K_I + int'(kx);
        pix_val  = in_range ? pixels[PIX_W'(pix_idx)] : '0;
        wt_val   = weights[WT_W'(wt_idx)];
        pix_ext  = {{(ACC_WIDTH-DATA_WIDTH){pix_val[DATA_WIDTH-1]}}, pix_val};
        wt_ext   = {{(ACC_WIDTH-WEIGHT_WIDTH){wt_val[WEIGHT_WIDTH-1]}}, wt_val};
        prod     = pix_ext * wt_ext;
        bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    end

    // Saturate the accumulator into the signed output range.
    always_comb begin
        fits = (acc[ACC_WIDTH-1:DATA_WIDTH-1] == {(ACC_WIDTH-DATA_WIDTH+1){acc[ACC_WIDTH-1]}});
        if (fits) begin
            sat_val = acc[DATA_WIDTH-1:0];
        end else if (acc[ACC_WIDTH-1]) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`ifdef CONV2D_MC_RELU_EN
        wr_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
        wr_val = sat_val;
`endif
        out_idx = OUT_W'(int'(oy) * OW_I + int'(ox));
    end

    // Datapath: tap counters, accumulator, result store and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ox   <= '0;
            oy   <= '0;
            c    <= '0;
            ky   <= '0;
            kx   <= '0;
            acc  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                out_mem[i] <= '0;
            end
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ox   <= '0;
                        oy   <= '0;
                        c    <= '0;
                        ky   <= '0;
                        kx   <= '0;
                        acc  <= bias_ext;
                        done <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc + prod;
                    if (kx == K_W'(KERNEL_SIZE - 1)) begin
                        kx <= '0;
                        if (ky == K_W'(KERNEL_SIZE - 1)) begin
                            ky <= '0;
                            c  <= (c == C_W'(IN_CHANNELS - 1)) ? '0 : c + C_W'(1);
                        end else begin
                            ky <= ky + K_W'(1);
                        end
                    end else begin
                        kx <= kx + K_W'(1);
                    end
                end
                WRITE: begin
                    out_mem[out_idx] <= wr_val;
                    acc              <= bias_ext;
                    if (ox == OW_W'(OUTPUT_WIDTH - 1)) begin
                        ox <= '0;
                        oy <= (oy == OW_W'(OUTPUT_WIDTH - 1)) ? '0 : oy + OW_W'(1);
                    end else begin
                        ox <= ox + OW_W'(1);
                    end
                    if (last_pix) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_mc.sv
// Self-checking bench for conv2d_mc: table-driven frames vs. a behavioural model,
// plus control sequences and a second instance with STRIDE=2, PADDING=0.
module tb_conv2d_mc;

    localparam int C   = 2;
    localparam int K   = 3;
    localparam int IW  = 4;
    localparam int OW  = 4;
    localparam int S   = 1;
    localparam int P   = 1;
    localparam int LAT = OW*OW*(C*K*K+1);

    localparam int FLT_W = C*K*K*8;
    localparam int IMG_W = C*IW*IW*32;
    localparam int OUT_W = OW*OW*32;

    localparam int IW2    = 5;
    localparam int OW2    = 2;
    localparam int IMG2_W = C*IW2*IW2*32;
    localparam int OUT2_W = OW2*OW2*32;
    localparam int LAT2   = OW2*OW2*(C*K*K+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [FLT_W-1:0]  filter;
    logic [31:0]       bias;
    logic [IMG_W-1:0]  input_image;
    logic [OUT_W-1:0]  output_image;
    logic              busy, done;

    logic              s_start;
    logic [FLT_W-1:0]  s_filter;
    logic [31:0]       s_bias;
    logic [IMG2_W-1:0] s_input_image;
    logic [OUT2_W-1:0] s_output_image;
    logic              s_busy, s_done;

    always #5 clk = ~clk;

    conv2d_mc u_dut (
        .clk(clk), .reset(reset), .start(start), .filter(filter), .bias(bias),
        .input_image(input_image), .output_image(output_image), .busy(busy), .done(done)
    );

    conv2d_mc #(.STRIDE(2), .PADDING(0), .INPUT_WIDTH(IW2)) u_dut_s2 (
        .clk(clk), .reset(reset), .start(s_start), .filter(s_filter), .bias(s_bias),
        .input_image(s_input_image), .output_image(s_output_image), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        string name;
        int    pmode;      // 0 random small, 1 constant, 2 random full range
        int    pval;
        int    wmode;      // 0 identity on ch0, 1 constant, 2 random
        int    wval;
        int    bias;
        bit    use_model;
        int    e_corner;
        int    e_edge;
        int    e_inner;
        int    mid_start;  // cycle at which a stray start is pulsed, -1 none
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int pix [C][IW][IW];
    int wt  [C][K][K];
    int bias_v;
    int exp_img [OW][OW];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pack_inputs();
        input_image = '0;
        for (int ch = C-1; ch >= 0; ch--)
            for (int y = IW-1; y >= 0; y--)
                for (int x = IW-1; x >= 0; x--)
                    input_image = (input_image << 32) | IMG_W'($unsigned(pix[ch][y][x]));
        filter = '0;
        for (int ch = C-1; ch >= 0; ch--)
            for (int y = K-1; y >= 0; y--)
                for (int x = K-1; x >= 0; x--)
                    filter = (filter << 8) | FLT_W'(8'($unsigned(wt[ch][y][x])));
        bias = $unsigned(bias_v);
    endtask

    // Direct convolution from the definition: padded sum, bias, clamp, optional ReLU.
    task automatic model();
        longint s;
        int ix, iy;
        for (int oy = 0; oy < OW; oy++) begin
            for (int ox = 0; ox < OW; ox++) begin
                s = longint'(bias_v);
                for (int ch = 0; ch < C; ch++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            ix = ox*S + kx - P;
                            iy = oy*S + ky - P;
                            if (ix >= 0 && ix < IW && iy >= 0 && iy < IW)
                                s += longint'(pix[ch][iy][ix]) * longint'(wt[ch][ky][kx]);
                        end
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef CONV2D_MC_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_img[oy][ox] = int'(s);
            end
        end
    endtask

    function automatic int out_at(input int i);
        return int'(32'(output_image >> (i*32)));
    endfunction

    function automatic int edge_class(input int ox, input int oy);
        int n;
        n = ((ox == 0 || ox == OW-1) ? 1 : 0) + ((oy == 0 || oy == OW-1) ? 1 : 0);
        return n;
    endfunction

    task automatic compare_outputs(input string name);
        for (int oy = 0; oy < OW; oy++)
            for (int ox = 0; ox < OW; ox++)
                check($sformatf("%s out[%0d][%0d]", name, oy, ox), out_at(oy*OW+ox), exp_img[oy][ox]);
    endtask

    // Start one frame; optionally pulse start mid-frame or abort with reset.
    task automatic run_frame(input string name, input int mid_start, input int reset_at, output bit aborted);
        int cnt;
        bit busy_ok;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " done_clear"}, done, 0);
        check({name, " busy_accept"}, busy, 1);
        cnt = 0;
        busy_ok = 1'b1;
        while (cnt < LAT + 50 && !done) begin
            if (cnt == mid_start) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cnt++;
            if (reset_at >= 0 && cnt == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                check({name, " rst_busy"}, busy, 0);
                check({name, " rst_done"}, done, 0);
                check({name, " rst_out_nonzero"}, (output_image != '0) ? 1 : 0, 0);
                aborted = 1'b1;
                return;
            end
            if (!done && !busy) busy_ok = 1'b0;
        end
        check({name, " latency"}, cnt, LAT);
        check({name, " busy_throughout"}, busy_ok, 1);
        check({name, " busy_after"}, busy, 0);
    endtask

    vec_t tbl [7];

    initial begin
        bit ab;
        int cnt;
        int e_min;
        int e_neg5;
`ifdef CONV2D_MC_RELU_EN
        e_min  = 0;
        e_neg5 = 0;
`else
        e_min  = int'(32'h8000_0000);
        e_neg5 = -5;
`endif
        tbl[0] = '{"identity", 0, 0, 0, 0, 0, 1'b1, 0, 0, 0, -1};
        tbl[1] = '{"padding", 1, 1, 1, 1, 0, 1'b0, 8, 12, 18, -1};
        tbl[2] = '{"sat_max", 1, 32'h7FFF_FFFF, 1, 127, 0, 1'b0,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1};
        tbl[3] = '{"sat_min", 1, int'(32'h8000_0000), 1, 127, 0, 1'b0, e_min, e_min, e_min, -1};
        tbl[4] = '{"bias_only", 0, 0, 1, 0, -5, 1'b0, e_neg5, e_neg5, e_neg5, -1};
        tbl[5] = '{"random_small", 0, 0, 2, 0, 17, 1'b1, 0, 0, 0, 50};
        tbl[6] = '{"random_full", 2, 0, 2, 0, -123456, 1'b1, 0, 0, 0, -1};

        reset = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        filter = '0;
        bias = '0;
        input_image = '0;
        s_filter = '0;
        s_bias = '0;
        s_input_image = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset out_nonzero", (output_image != '0) ? 1 : 0, 0);
        check("reset s2 done", s_done, 0);

        foreach (tbl[t]) begin
            for (int ch = 0; ch < C; ch++)
                for (int y = 0; y < IW; y++)
                    for (int x = 0; x < IW; x++)
                        case (tbl[t].pmode)
                            0:       pix[ch][y][x] = int'($urandom_range(2000)) - 1000;
                            1:       pix[ch][y][x] = tbl[t].pval;
                            default: pix[ch][y][x] = int'($urandom());
                        endcase
            for (int ch = 0; ch < C; ch++)
                for (int y = 0; y < K; y++)
                    for (int x = 0; x < K; x++)
                        case (tbl[t].wmode)
                            0:       wt[ch][y][x] = (ch == 0 && y == K/2 && x == K/2) ? 1 : 0;
                            1:       wt[ch][y][x] = tbl[t].wval;
                            default: wt[ch][y][x] = int'($urandom_range(255)) - 128;
                        endcase
            bias_v = tbl[t].bias;
            if (tbl[t].use_model) begin
                model();
            end else begin
                for (int oy = 0; oy < OW; oy++)
                    for (int ox = 0; ox < OW; ox++)
                        case (edge_class(ox, oy))
                            2:       exp_img[oy][ox] = tbl[t].e_corner;
                            1:       exp_img[oy][ox] = tbl[t].e_edge;
                            default: exp_img[oy][ox] = tbl[t].e_inner;
                        endcase
            end
            pack_inputs();
            run_frame(tbl[t].name, tbl[t].mid_start, -1, ab);
            compare_outputs(tbl[t].name);
            if (tbl[t].wmode == 0)
                for (int i = 0; i < OW*OW; i++)
                    check($sformatf("identity ch0[%0d]", i), out_at(i), pix[0][i/IW][i%IW]);
        end

        // done holds in IDLE while start stays low
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", done, 1);

        // abort with reset at cycle 100, then a full frame from scratch
        for (int ch = 0; ch < C; ch++)
            for (int y = 0; y < IW; y++)
                for (int x = 0; x < IW; x++)
                    pix[ch][y][x] = int'($urandom_range(60000)) - 30000;
        for (int ch = 0; ch < C; ch++)
            for (int y = 0; y < K; y++)
                for (int x = 0; x < K; x++)
                    wt[ch][y][x] = int'($urandom_range(255)) - 128;
        bias_v = int'($urandom_range(1000)) - 500;
        pack_inputs();
        model();
        run_frame("reset_abort", -1, 100, ab);
        check("reset_abort taken", ab, 1);
        run_frame("after_reset", -1, -1, ab);
        compare_outputs("after_reset");

        // stride 2, no padding, 5x5 input: pixel = x+y on ch0, ch0 weights 1, ch1 weights 0
        s_input_image = '0;
        for (int ch = C-1; ch >= 0; ch--)
            for (int y = IW2-1; y >= 0; y--)
                for (int x = IW2-1; x >= 0; x--)
                    s_input_image = (s_input_image << 32)
                        | IMG2_W'((ch == 0) ? 32'(x + y) : $urandom());
        s_filter = '0;
        for (int i = C*K*K-1; i >= 0; i--)
            s_filter = (s_filter << 8) | FLT_W'((i < K*K) ? 8'd1 : 8'd0);
        s_bias = '0;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cnt = 0;
        while (cnt < LAT2 + 50 && !s_done) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("s2 latency", cnt, LAT2);
        check("s2 out[0]", int'(32'(s_output_image >> 0)), 18);
        check("s2 out[1]", int'(32'(s_output_image >> 32)), 36);
        check("s2 out[2]", int'(32'(s_output_image >> 64)), 36);
        check("s2 out[3]", int'(32'(s_output_image >> 96)), 54);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
